// File: rtl/alu_defs_pkg.sv
// alu_defs: shared opcode constants and default widths for the ALU issue stage.
package alu_defs;
  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SHL = 4'd4,
    ALU_SHR = 4'd5
  } alu_op_e;
endpackage

// File: rtl/alu_issue_stage_regfile.sv
// alu_regfile: register file with two operand read ports, a debug read port and one write port.
module alu_regfile #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic [DATA_W-1:0] o_dbg_data
);
  logic [DATA_W-1:0] r_mem [2**REG_AW];
  // register 0 is never written, so it always reads back as zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 2**REG_AW; i++) r_mem[i] <= '0;
    else if (i_we && i_waddr != '0)
      r_mem[i_waddr] <= i_wdata;
  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: EX/WB issue stage feeding an external ALU; FORWARD_EN enables
// operand bypassing, otherwise RAW hazards stall the input.
module alu_issue_stage
  import alu_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  logic              r_ex_valid, r_wb_valid;
  logic [3:0]        r_ex_op;
  logic [REG_AW-1:0] r_ex_rd, r_wb_rd;
  logic [DATA_W-1:0] r_ex_a, r_ex_b, r_wb_data;
  logic [DATA_W-1:0] w_rf_a, w_rf_b, w_a, w_rs2, w_b;
  logic              w_ex_a, w_wb_a, w_ex_b, w_wb_b, w_accept;

  alu_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .i_we(r_wb_valid), .i_waddr(r_wb_rd), .i_wdata(r_wb_data),
    .i_raddr_a(in_rs1), .i_raddr_b(in_rs2), .i_dbg_addr(dbg_addr),
    .o_rdata_a(w_rf_a), .o_rdata_b(w_rf_b), .o_dbg_data(dbg_data)
  );

  assign w_ex_a = r_ex_valid && in_rs1 != '0 && in_rs1 == r_ex_rd;
  assign w_wb_a = r_wb_valid && in_rs1 != '0 && in_rs1 == r_wb_rd;
  assign w_ex_b = !in_use_imm && r_ex_valid && in_rs2 != '0 && in_rs2 == r_ex_rd;
  assign w_wb_b = !in_use_imm && r_wb_valid && in_rs2 != '0 && in_rs2 == r_wb_rd;

`ifdef FORWARD_EN
  assign w_a      = w_ex_a ? alu_result : w_wb_a ? r_wb_data : w_rf_a;
  assign w_rs2    = w_ex_b ? alu_result : w_wb_b ? r_wb_data : w_rf_b;
  assign in_ready = 1'b1;
`else
  assign w_a      = w_rf_a;
  assign w_rs2    = w_rf_b;
  assign in_ready = !(w_ex_a || w_wb_a || w_ex_b || w_wb_b);
`endif

  assign w_b      = in_use_imm ? in_imm : w_rs2;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_rd    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_ex_op <= in_op;
        r_ex_rd <= in_rd;
        r_ex_a  <= w_a;
        r_ex_b  <= w_b;
      end
      r_wb_valid <= r_ex_valid;
      if (r_ex_valid) begin
        r_wb_rd   <= r_ex_rd;
        r_wb_data <= alu_result;
      end
    end

  assign alu_a    = r_ex_valid ? r_ex_a : '0;
  assign alu_b    = r_ex_valid ? r_ex_b : '0;
  assign alu_op   = r_ex_valid ? r_ex_op : '0;
  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed stimulus checked against an architectural in-order model.
module tb_alu_issue_stage;
  import alu_defs::*;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid, in_ready, in_use_imm, wb_valid;
  logic [3:0]    in_op, alu_op;
  logic [AW-1:0] in_rd, in_rs1, in_rs2, wb_rd, dbg_addr;
  logic [DW-1:0] in_imm, alu_a, alu_b, alu_result, wb_data, dbg_data;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [DW-1:0] alu_f(logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SHL: return a << b;
      ALU_SHR: return a >> b;
      default: return '0;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_op, alu_a, alu_b);

  int n_chk = 0, n_fail = 0, st;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [AW-1:0] rd;
    logic [3:0]    op;
    logic [DW-1:0] a, b, res;
    int            age;
  } inst_t;

  inst_t         q[$];
  logic [DW-1:0] m_arch [8];
  logic [DW-1:0] m_rf   [8];
  bit            acc = 0, run_chk = 0;

  // age = edges since accept: 1 in EX, 2 in WB, 3 committed to the register file
  always @(posedge clk or negedge rst_n) begin
    inst_t e;
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 8; i++) begin
        m_arch[i] = '0;
        m_rf[i]   = '0;
      end
    end else begin
      foreach (q[i]) q[i].age++;
      while (q.size() > 0 && q[0].age == 3) begin
        if (q[0].rd != 0) m_rf[q[0].rd] = q[0].res;
        void'(q.pop_front());
      end
      if (acc) begin
        e.rd  = in_rd;
        e.op  = in_op;
        e.a   = m_arch[in_rs1];
        e.b   = in_use_imm ? in_imm : m_arch[in_rs2];
        e.res = alu_f(in_op, e.a, e.b);
        e.age = 1;
        q.push_back(e);
        if (in_rd != 0) m_arch[in_rd] = e.res;
      end
    end
  end

  always @(negedge clk) begin
    bit haz, exp_ready;
    int ex_i, wb_i;
    #1;
    acc = 0;
    if (rst_n && run_chk) begin
      haz = 0; ex_i = -1; wb_i = -1;
      foreach (q[i]) begin
        if (q[i].rd != 0 && (in_rs1 == q[i].rd || (!in_use_imm && in_rs2 == q[i].rd))) haz = 1;
        if (q[i].age == 1) ex_i = i;
        if (q[i].age == 2) wb_i = i;
      end
`ifdef FORWARD_EN
      exp_ready = 1;
`else
      exp_ready = !haz;
`endif
      chk("in_ready", in_ready, exp_ready);
      if (ex_i >= 0) begin
        chk("alu_a", alu_a, q[ex_i].a);
        chk("alu_b", alu_b, q[ex_i].b);
        chk("alu_op", alu_op, q[ex_i].op);
      end else
        chk("alu_idle", {alu_op, alu_a, alu_b}, 0);
      chk("wb_valid", wb_valid, wb_i >= 0);
      if (wb_i >= 0) begin
        chk("wb_rd", wb_rd, q[wb_i].rd);
        chk("wb_data", wb_data, q[wb_i].res);
      end
      chk("dbg_data", dbg_data, m_rf[dbg_addr]);
      acc = in_valid && in_ready;
    end
  end

  task automatic issue(logic [3:0] op, logic [AW-1:0] rd, logic [AW-1:0] rs1, logic [AW-1:0] rs2,
                       logic ui, logic [DW-1:0] imm, output int stalls);
    @(negedge clk);
    in_valid = 1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_use_imm = ui; in_imm = imm;
    stalls = 0;
    #2;
    while (!in_ready && stalls < 10) begin
      stalls++;
      @(negedge clk);
      #2;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0;
    end
  endtask

  task automatic wb_chk(string name, logic [DW-1:0] exp);
    @(negedge clk);
    in_valid = 0;
    @(posedge clk);
    #1;
    chk({name, "_valid"}, wb_valid, 1);
    chk(name, wb_data, exp);
  endtask

  task automatic rf_chk(string name, logic [AW-1:0] addr, logic [DW-1:0] exp);
    @(posedge clk);
    #1;
    dbg_addr = addr;
    #1;
    chk(name, dbg_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    in_valid = 0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_use_imm = 0; in_imm = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_fields", {wb_rd, wb_data}, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
    for (int a = 0; a < 8; a++) begin
      dbg_addr = a[AW-1:0];
      #1;
      chk("rst_dbg", dbg_data, 0);
    end
    @(negedge clk);
    rst_n = 1;
    run_chk = 1;

    issue(ALU_ADD, 1, 0, 0, 1, 10, st);
    issue(ALU_ADD, 2, 0, 0, 1, 20, st);
    idle(2);
    issue(ALU_ADD, 3, 1, 2, 0, 0, st);
    chk("indep_stall", st, 0);
    wb_chk("indep_wb", 30);
    rf_chk("indep_rf3", 3, 30);

    issue(ALU_ADD, 1, 0, 0, 1, 50, st);
    issue(ALU_SUB, 1, 1, 0, 1, 30, st);
`ifdef FORWARD_EN
    chk("dep_stall", st, 0);
`else
    chk("dep_stall", st, 2);
`endif
    wb_chk("dep_wb", 20);
    rf_chk("dep_rf1", 1, 20);

    issue(ALU_ADD, 4, 0, 0, 1, 85, st);
    issue(ALU_ADD, 5, 0, 0, 1, 170, st);
    issue(ALU_AND, 1, 4, 5, 0, 0, st);
    wb_chk("and_wb", 0);
    issue(ALU_OR, 2, 4, 5, 0, 0, st);
    wb_chk("or_wb", 255);
    issue(ALU_ADD, 3, 0, 0, 1, 12, st);
    issue(ALU_SHL, 3, 3, 0, 1, 2, st);
    wb_chk("shl_wb", 48);
    issue(ALU_SHR, 3, 3, 0, 1, 2, st);
    wb_chk("shr_wb", 12);

    issue(ALU_ADD, 0, 0, 0, 1, 5, st);
    issue(ALU_ADD, 6, 0, 0, 1, 1, st);
    chk("r0_stall", st, 0);
    wb_chk("r0_wb", 1);
    rf_chk("r0_rf6", 6, 1);
    rf_chk("r0_rf0", 0, 0);

    issue(ALU_ADD, 7, 0, 0, 1, 9, st);
    #1;
    chk("mid_ex_b", alu_b, 9);
    rst_n = 0;
    @(negedge clk);
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("mid_rst_wb", wb_valid, 0);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_wb", wb_valid, 0);
    end
    rf_chk("mid_rf7", 7, 0);
    rf_chk("mid_rf3", 3, 0);

    issue(ALU_ADD, 2, 0, 0, 1, 7, st);
    issue(ALU_SHL, 2, 2, 0, 1, 1, st);
    wb_chk("post_shl", 14);
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width.
REQ-002 SHALL have parameter REG_AW, default 3, register address width (8 registers).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, instruction present.
REQ-006 SHALL have port in_ready, output, 1, stage accepts the instruction this cycle.
REQ-007 SHALL have port in_op, input, 4, ALU opcode: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 shl, 0101 shr.
REQ-008 SHALL have ports in_rd, in_rs1 and in_rs2, input, REG_AW each, destination and source register indices.
REQ-009 SHALL have ports in_use_imm (input, 1) and in_imm (input, DATA_W); when in_use_imm=1, B is in_imm instead of rs2.
REQ-010 SHALL have ports alu_a and alu_b (output, DATA_W) and alu_op (output, 4), driven to the external combinational ALU.
REQ-011 SHALL have port alu_result, input, DATA_W, returned combinationally by the ALU.
REQ-012 SHALL have ports wb_valid (output, 1), wb_rd (output, REG_AW) and wb_data (output, DATA_W), the writeback register.
REQ-013 SHALL have ports dbg_addr (input, REG_AW) and dbg_data (output, DATA_W), a combinational register-file read port.

Function
REQ-014 SHALL accept an instruction on a rising edge where in_valid=1 and in_ready=1.
REQ-015 SHALL read operands during the accept cycle and register op, rd, A and B into the EX register, setting ex_valid.
REQ-016 SHALL drive alu_a, alu_b and alu_op from the EX register; these outputs are 0 when ex_valid=0.
REQ-017 SHALL capture alu_result, ex_rd and ex_valid into the WB register one edge after accept.
REQ-018 SHALL write wb_data into rf[wb_rd] at the following edge when wb_valid=1; result latency is accept to wb_valid 1 cycle, and accept to register-file update 2 cycles.
REQ-019 SHALL hardwire register 0: reads return 0, writes are dropped, and it never causes a hazard.
REQ-020 SHALL treat a source as hazardous when it is nonzero and equals ex_rd while ex_valid=1, or equals wb_rd while wb_valid=1; rs2 is ignored when in_use_imm=1.
REQ-021 SHALL deassert in_ready only for a hazard stall (per Configuration); there is no downstream backpressure.
REQ-022 SHALL insert a bubble (ex_valid=0) into EX on any cycle without an accept.
REQ-023 SHALL truncate all values to DATA_W bits; no flags are produced.
REQ-024 SHALL make dbg_data reflect register-file contents only, not in-flight results.

Reset
REQ-025 SHALL, while rst_n=0, clear all registers to 0, including ex_valid, wb_valid and the EX/WB fields; alu_a, alu_b, alu_op, wb_rd and wb_data are 0 and in_ready=1.
REQ-026 SHALL discard in-flight instructions when reset is asserted mid-operation; no register-file write occurs.

Configuration
REQ-027 SHALL, when FORWARD_EN is defined, bypass hazards without stalling, with priority EX (alu_result) over WB (wb_data) over the register file.
REQ-028 SHALL, when FORWARD_EN is undefined, hold in_ready=0 while any hazard exists, so a back-to-back dependency stalls 2 cycles.

Structure
REQ-029 SHALL take opcode constants (ALU_ADD..ALU_SHR), DATA_W and REG_AW defaults from the shared header alu_defs.
REQ-030 SHALL implement the register file as sub-module alu_regfile, with two combinational read ports, one debug read port and one synchronous write port.

Verification
REQ-031 SHALL cover reset: in_ready=1, wb_valid=0 and dbg_data=0 for all 8 addresses.
REQ-032 SHALL cover independent operations: r1=r0+10(imm), r2=r0+20(imm), two idle cycles, then r3=r1+r2 -> wb_data=30 and rf[3]=30.
REQ-033 SHALL cover a back-to-back dependency: r1=r0+50(imm), then immediately r1=r1-30(imm) -> wb_data=20; with FORWARD_EN in_ready stays 1, without it in_ready=0 for exactly 2 cycles.
REQ-034 SHALL cover logic and shift operations: r4=85 and r5=170 loaded, then AND -> 0, OR -> 255, 12 shl 2 -> 48, 48 shr 2 -> 12.
REQ-035 SHALL cover register 0: r0=r0+5(imm), then r6=r0+1(imm) -> no stall, rf[0]=0, wb_data=1.
REQ-036 SHALL cover reset mid-operation: reset pulsed with ex_valid=1 for r7=r0+9 -> wb_valid never asserts and rf[7]=0.
